// File: rtl/can_tail_sequencer.sv
// CAN frame-tail sequencer: CRC delimiter through intermission.
// Arms the EOF checker, folds its verdict and parks on tail errors.
module can_tail_sequencer #(
  parameter int EOF_LEN  = 7,
  parameter int IFS_LEN  = 3,
  parameter int IDLE_LEN = 11
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       crc_last,
  input  logic       EOF_Error,
  output logic       EOF_Flag,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       ack_missing,
  output logic       form_err_n,
  output logic [2:0] err_code,
  output logic       overload,
  output logic       bus_idle,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CRC_DEL  = 3'd1;
  localparam logic [2:0] S_ACK_SLOT = 3'd2;
  localparam logic [2:0] S_ACK_DEL  = 3'd3;
  localparam logic [2:0] S_EOF      = 3'd4;
  localparam logic [2:0] S_IFS      = 3'd5;
  localparam logic [2:0] S_ERR_HOLD = 3'd6;

  localparam logic [3:0] EOF_LAST  = 4'(EOF_LEN - 1);
  localparam logic [3:0] IFS_LAST  = 4'(IFS_LEN - 1);
  localparam logic [3:0] IDLE_LAST = 4'(IDLE_LEN - 1);

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_CRC   = 3'd1;
  localparam logic [2:0] E_ACK   = 3'd2;
  localparam logic [2:0] E_EOF   = 3'd3;
  localparam logic [2:0] E_OVLD  = 3'd4;

  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic [3:0] cnt_sat;
  logic [2:0] nxt;
  logic [2:0] form_code;
  logic       start;
  logic       ack_set;
  logic       arm;
  logic       done;
  logic       ovl;
  logic       eof_win;
  logic       eof_bad;

  // Checker output lags one bit, so the window runs one bit into IFS.
  assign eof_win = ((state == S_EOF) && (cnt != 4'd0))
                || ((state == S_IFS) && (cnt == 4'd0));
  assign eof_bad = eof_win && !EOF_Error;
  assign cnt_sat = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  always_comb begin
    nxt       = state;
    form_code = E_NONE;
    start     = 1'b0;
    ack_set   = 1'b0;
    arm       = 1'b0;
    done      = 1'b0;
    ovl       = 1'b0;
    case (state)
      S_IDLE: begin
        if (crc_last) begin
          nxt   = S_CRC_DEL;
          start = 1'b1;
        end
      end
      S_CRC_DEL: begin
        if (RX) begin
          nxt = S_ACK_SLOT;
        end else begin
          nxt       = S_ERR_HOLD;
          form_code = E_CRC;
        end
      end
      S_ACK_SLOT: begin
        nxt     = S_ACK_DEL;
        ack_set = RX;
      end
      S_ACK_DEL: begin
        if (RX) begin
          nxt = S_EOF;
          arm = 1'b1;
        end else begin
          nxt       = S_ERR_HOLD;
          form_code = E_ACK;
        end
      end
      S_EOF: begin
        if (eof_bad) begin
          nxt       = S_ERR_HOLD;
          form_code = E_EOF;
        end else if (cnt == EOF_LAST) begin
          nxt = S_IFS;
        end
      end
      S_IFS: begin
        if (eof_bad) begin
          nxt       = S_ERR_HOLD;
          form_code = E_EOF;
        end else if (cnt == IFS_LAST) begin
          // a dominant last bit is the next SOF
          nxt  = S_IDLE;
          done = 1'b1;
        end else if (!RX) begin
          nxt = S_ERR_HOLD;
          ovl = 1'b1;
        end
      end
      S_ERR_HOLD: begin
        if (RX && (cnt == IDLE_LAST)) begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_n = 4'd0;
    if (nxt == state) begin
      unique case (1'b1)
        (state == S_IDLE):     cnt_n = 4'd0;
        (state == S_ERR_HOLD): cnt_n = RX ? cnt_sat : 4'd0;
        default:               cnt_n = cnt_sat;
      endcase
    end
  end

  always_ff @(posedge SP) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      EOF_Flag    <= 1'b1;
      form_err_n  <= 1'b1;
      frame_ok    <= 1'b1;
      bus_idle    <= 1'b1;
      ack_missing <= 1'b0;
      err_code    <= E_NONE;
      frame_done  <= 1'b0;
      overload    <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_n;
      EOF_Flag   <= !arm;
      frame_done <= done;
      overload   <= ovl;
      bus_idle   <= (nxt == S_IDLE);
      if (start) begin
        ack_missing <= 1'b0;
        form_err_n  <= 1'b1;
        err_code    <= E_NONE;
      end
      if (ack_set) begin
        ack_missing <= 1'b1;
      end
      if (form_code != E_NONE) begin
        err_code   <= form_code;
        form_err_n <= 1'b0;
        frame_ok   <= 1'b0;
      end
      if (ovl) begin
        err_code <= E_OVLD;
      end
      if (done) begin
        frame_ok <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_can_tail_sequencer.sv
// Bench for can_tail_sequencer: directed and random tails checked
// against a bit-position model of the frame tail.
module tb_can_tail_sequencer;

  logic       SP = 1'b0;
  logic       reset = 1'b0;
  logic       RX = 1'b1;
  logic       crc_last = 1'b0;
  logic       EOF_Error = 1'b1;
  logic       EOF_Flag;
  logic       frame_done;
  logic       frame_ok;
  logic       ack_missing;
  logic       form_err_n;
  logic [2:0] err_code;
  logic       overload;
  logic       bus_idle;
  logic [2:0] state;

  int compared = 0;
  int mismatched = 0;

  // latched-output model
  logic       m_ok = 1'b1;
  logic       m_ack = 1'b0;
  logic       m_fe = 1'b1;
  logic [2:0] m_code = 3'd0;

  can_tail_sequencer dut (
    .SP(SP),
    .reset(reset),
    .RX(RX),
    .crc_last(crc_last),
    .EOF_Error(EOF_Error),
    .EOF_Flag(EOF_Flag),
    .frame_done(frame_done),
    .frame_ok(frame_ok),
    .ack_missing(ack_missing),
    .form_err_n(form_err_n),
    .err_code(err_code),
    .overload(overload),
    .bus_idle(bus_idle),
    .state(state)
  );

  always #5 SP = ~SP;

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input string nm,
                     input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s/%s: got %0d expected %0d", tag, nm, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] est,
                            input logic eflag, input logic edone,
                            input logic eovl);
    chk(tag, "state", {1'b0, state}, {1'b0, est});
    chk(tag, "bus_idle", {3'b0, bus_idle}, {3'b0, est == 3'd0});
    chk(tag, "EOF_Flag", {3'b0, EOF_Flag}, {3'b0, eflag});
    chk(tag, "frame_done", {3'b0, frame_done}, {3'b0, edone});
    chk(tag, "overload", {3'b0, overload}, {3'b0, eovl});
    chk(tag, "frame_ok", {3'b0, frame_ok}, {3'b0, m_ok});
    chk(tag, "ack_missing", {3'b0, ack_missing}, {3'b0, m_ack});
    chk(tag, "form_err_n", {3'b0, form_err_n}, {3'b0, m_fe});
    chk(tag, "err_code", {1'b0, err_code}, {1'b0, m_code});
  endtask

  task automatic cyc(input logic rx, input logic crc,
                     input logic ee, input logic rst);
    @(negedge SP);
    RX = rx;
    crc_last = crc;
    EOF_Error = ee;
    reset = rst;
    @(posedge SP);
    #1;
  endtask

  task automatic model_reset();
    m_ok = 1'b1;
    m_ack = 1'b0;
    m_fe = 1'b1;
    m_code = 3'd0;
  endtask

  // rxv[p]/eev[p]: RX and EOF_Error at the p-th edge after crc_last.
  // Tail positions: 1 CRC delim, 2 ACK slot, 3 ACK delim,
  // 4..10 EOF bits, 11..13 intermission bits.
  task automatic run_frame(input string tag, input logic [13:0] rxv,
                           input logic [13:0] eev, input int rst_p,
                           input logic [31:0] holdv, input int holdn);
    int endp;
    int kind;
    int run;
    logic [2:0] est;
    logic r;
    endp = 13;
    kind = 0;
    for (int p = 1; p <= 13; p++) begin
      if (p == 1 && !rxv[1]) begin endp = 1; kind = 1; break; end
      if (p == 3 && !rxv[3]) begin endp = 3; kind = 2; break; end
      if (p >= 5 && p <= 11 && !eev[p]) begin
        endp = p; kind = 3; break;
      end
      if ((p == 11 || p == 12) && !rxv[p]) begin
        endp = p; kind = 4; break;
      end
    end

    cyc(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    m_ack = 1'b0;
    m_fe = 1'b1;
    m_code = 3'd0;
    check_outs(tag, 3'd1, 1'b1, 1'b0, 1'b0);

    for (int p = 1; p <= endp; p++) begin
      if (p == rst_p) begin
        cyc(rxv[p], 1'($urandom_range(0, 1)), eev[p], 1'b0);
        model_reset();
        check_outs({tag, "_rst"}, 3'd0, 1'b1, 1'b0, 1'b0);
        return;
      end
      cyc(rxv[p], 1'($urandom_range(0, 1)), eev[p], 1'b1);
      if (p == 2) m_ack = rxv[2];
      if (p == endp) begin
        est = (kind == 0) ? 3'd0 : 3'd6;
        if (kind >= 1 && kind <= 3) begin
          m_code = 3'(kind);
          m_fe = 1'b0;
          m_ok = 1'b0;
        end else if (kind == 4) begin
          m_code = 3'd4;
        end else begin
          m_ok = 1'b1;
        end
      end else if (p <= 2) begin
        est = 3'(p + 1);
      end else if (p <= 9) begin
        est = 3'd4;
      end else begin
        est = 3'd5;
      end
      check_outs(tag, est, !(p == 3 && endp != 3),
                 (p == endp && kind == 0), (p == endp && kind == 4));
    end

    if (kind != 0) begin
      run = 0;
      for (int i = 0; i < holdn + 11; i++) begin
        r = (i < holdn) ? holdv[i] : 1'b1;
        cyc(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        run = r ? run + 1 : 0;
        check_outs({tag, "_hold"}, (run == 11) ? 3'd0 : 3'd6,
                   1'b1, 1'b0, 1'b0);
        if (run == 11) break;
      end
    end

    for (int g = 0; g < 2; g++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      check_outs({tag, "_gap"}, 3'd0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  localparam logic [13:0] ALL1  = 14'h3FFF;
  localparam logic [13:0] CLEAN = 14'h3FFB;

  initial begin
    logic [13:0] rv;
    logic [13:0] ev;
    int rp;

    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check_outs("idle", 3'd0, 1'b1, 1'b0, 1'b0);

    run_frame("clean", CLEAN, ALL1, -1, 32'h0, 0);
    run_frame("crc_del", CLEAN & ~14'h0002, ALL1, -1, 32'h1F, 6);
    run_frame("ack_miss", ALL1, ALL1, -1, 32'h0, 0);
    run_frame("ack_del", CLEAN & ~14'h0008, ALL1, -1, 32'h0, 0);
    run_frame("eof_err", CLEAN, ALL1 & ~14'h0100, -1, 32'h0, 0);
    run_frame("ovl_b1", CLEAN & ~14'h1000, ALL1, -1, 32'h0, 0);
    run_frame("sof_b2", CLEAN & ~14'h2000, ALL1, -1, 32'h0, 0);
    run_frame("ovl_eof", CLEAN & ~14'h0800, ALL1 & ~14'h0800,
              -1, 32'h0, 0);
    run_frame("eof_late", CLEAN, ALL1 & ~14'h0020, -1, 32'h0, 0);
    run_frame("eof_ign", CLEAN, ALL1 & ~14'h1010, -1, 32'h0, 0);
    run_frame("rst_eof3", CLEAN, ALL1, 7, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      rv = '1;
      ev = '1;
      for (int p = 1; p <= 13; p++) begin
        rv[p] = ($urandom_range(0, 19) != 0);
        ev[p] = ($urandom_range(0, 29) != 0);
      end
      rv[2] = 1'($urandom_range(0, 1));
      rp = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 13)) : -1;
      run_frame("rand", rv, ev, rp, $urandom | $urandom,
                int'($urandom_range(0, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/can_tail_sequencer.md
# can_tail_sequencer

Frame-tail sequencer for the CAN decoder. From the sample after the last CRC bit it walks CRC delimiter, ACK slot, ACK delimiter, EOF and intermission. It fires the one-sample EOF_Flag strobe that arms the EOF checker and folds the checker's active-low EOF_Error into a per-frame verdict. On any tail error it parks the decoder until the bus shows 11 recessive bits.

## Interface
- EOF_LEN, 7: EOF bit count.
- IFS_LEN, 3: intermission bit count.
- IDLE_LEN, 11: consecutive recessive bits required to leave error recovery.

- SP  in  1  sample-point clock; all logic on posedge SP.
- reset  in  1  synchronous, active-low; sampled on posedge SP.
- RX  in  1  sampled bus bit (1 = recessive).
- crc_last  in  1  high on the SP sampling the last CRC bit.
- EOF_Error  in  1  active-low error from the EOF checker.
- EOF_Flag  out  1  active-low arm strobe to the EOF checker.
- frame_done  out  1  one-cycle pulse at the end of a clean tail.
- frame_ok  out  1  latched verdict of the last tail (1 = no error).
- ack_missing  out  1  latched; ACK slot sampled recessive.
- form_err_n  out  1  active-low latched form/EOF error.
- err_code  out  3  0 none, 1 CRC delim, 2 ACK delim, 3 EOF, 4 overload.
- overload  out  1  one-cycle pulse on a dominant bit in intermission bits 0-1.
- bus_idle  out  1  high in IDLE.
- state  out  3  current state (debug).

## Operation
- States: IDLE(0), CRC_DEL(1), ACK_SLOT(2), ACK_DEL(3), EOF(4), IFS(5), ERR_HOLD(6).
- Bit counter `cnt` is 4 bits and is cleared on every state entry.
- IDLE
  - crc_last=1 → CRC_DEL.
  - On that same edge: clear ack_missing, set form_err_n=1, set err_code=0.
  - crc_last in any other state is ignored.
- CRC_DEL
  - RX=1 → ACK_SLOT.
  - RX=0 → ERR_HOLD with err_code=1, form_err_n=0, frame_ok=0.
- ACK_SLOT
  - RX=1 sets ack_missing=1.
  - Always → ACK_DEL. A missing ACK is flagged only; it does not abort the tail.
- ACK_DEL
  - RX=1 → EOF, and EOF_Flag=0 for exactly the next cycle.
  - RX=0 → ERR_HOLD with err_code=2, form_err_n=0, frame_ok=0.
- EOF
  - Lasts EOF_LEN cycles (cnt 0..EOF_LEN-1).
  - EOF_Flag returns to 1 after the first cycle, so the checker is never re-armed.
  - EOF_Error is monitored from EOF cnt=1 through IFS cnt=0, which covers the checker's one-cycle output latency.
  - EOF_Error=0 in that window → ERR_HOLD with err_code=3, form_err_n=0, frame_ok=0.
  - An EOF error takes priority over an IFS overload on the same edge.
- IFS
  - Lasts IFS_LEN cycles.
  - RX=0 at cnt 0 or 1 → overload pulse, err_code=4, → ERR_HOLD. frame_ok is unaffected, since the frame itself was valid.
  - RX=0 at cnt=IFS_LEN-1 counts as the SOF of the next frame: frame_done pulse, frame_ok=1 → IDLE.
  - Completing all IFS_LEN bits recessive: frame_done pulse, frame_ok=1 → IDLE.
  - Either clean exit also asserts frame_done and sets frame_ok=1.
- ERR_HOLD
  - RX=1 increments cnt; RX=0 clears it.
  - cnt reaching IDLE_LEN-1 with RX=1 → IDLE.
  - cnt saturates and never wraps.
- reset=0 on any edge forces these values, overriding all other actions:
  - state=IDLE
  - EOF_Flag=1, form_err_n=1, frame_ok=1, bus_idle=1
  - ack_missing=0, err_code=0, frame_done=0, overload=0
  - cnt=0

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Sample k is the SP carrying the last CRC bit. Relative to it:
  - CRC_DEL is entered at k+1.
  - EOF_Flag is low during sample k+4, the first EOF bit.
  - The last EOF bit is k+10.
  - With a fully recessive intermission, frame_done is high during k+14.
- frame_done and overload are single-cycle pulses. Errors latch until the next crc_last accepted in IDLE, or until reset.
- Minimum error recovery is IDLE_LEN cycles of RX=1 after entering ERR_HOLD.

## Test plan
- Clean tail (crc_last, then RX = 1,0,1, seven 1s, three 1s):
  - EOF_Flag low exactly one cycle at k+4.
  - frame_done at k+14, frame_ok=1, ack_missing=0, err_code=0.
- CRC delimiter sampled 0:
  - err_code=1, form_err_n=0, state=6.
  - Returns to IDLE only after 11 consecutive 1s. A 0 injected after 5 ones restarts the count.
- ACK slot recessive, rest clean: ack_missing=1, frame_done still pulses, frame_ok=1.
- EOF_Error driven 0 at EOF bit 4: err_code=3, frame_ok=0, no frame_done.
- Dominant RX at IFS bit 1: overload pulse, err_code=4. Dominant RX at IFS bit 2 instead: frame_done, IDLE.
- reset=0 asserted during EOF cnt=3: next edge shows IDLE, EOF_Flag=1, all outputs at reset values. crc_last during ERR_HOLD is ignored.
